// File: rtl/mul_result_queue.sv
// mul_result_queue: buffers multiplier result words for one vector
// instruction and streams them, in order, to the VRF write port.
// An issue handshake arms two counters with the instruction length: one
// counts result words still to be accepted, the other counts words still
// to be written. done_o pulses one cycle after the final write.
//
// Optional feature: define MUL_RESULT_QUEUE_PERF_EN to add stall_cnt_o,
// a saturating count of cycles where a write is offered but not taken.
module mul_result_queue #(
  parameter int Depth    = 4,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [CntWidth-1:0] issue_len_i,
  input  logic [63:0]         result_i,
  input  logic [7:0]          mask_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [63:0]         wdata_o,
  output logic [7:0]          wbe_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic                done_o
`ifdef MUL_RESULT_QUEUE_PERF_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  localparam int PtrW = $clog2(Depth);
  localparam int OccW = $clog2(Depth) + 1;
  localparam logic [OccW-1:0] FullOcc = OccW'(Depth);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                w_done_nxt;
  logic                r_done;
  logic [CntWidth-1:0] r_acc_cnt;
  logic [CntWidth-1:0] r_wr_cnt;
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [OccW-1:0]     r_occ;
  logic [63:0]         r_mem_data [Depth];
  logic [7:0]          r_mem_be   [Depth];

  logic w_full;
  logic w_empty;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_last_acc;
  logic w_last_wr;

  assign w_full     = (r_occ == FullOcc);
  assign w_empty    = (r_occ == '0);
  assign w_last_acc = (r_acc_cnt == CntWidth'(1));
  assign w_last_wr  = (r_wr_cnt == CntWidth'(1));

  // Handshake qualifiers; ready_o depends only on registered state/occupancy
  assign issue_ready_o = (r_state == IDLE);
  assign ready_o       = (r_state == ACTIVE) & ~w_full;
  assign w_issue       = issue_valid_i & issue_ready_o;
  assign w_push        = valid_i & ready_o;
  assign w_pop         = wvalid_o & wready_i;

  // Head of queue drives the write port; forced to zero while nothing is held
  assign wvalid_o = ~w_empty;
  assign wdata_o  = w_empty ? 64'd0 : r_mem_data[r_rd_ptr];
  assign wbe_o    = w_empty ? 8'd0  : r_mem_be[r_rd_ptr];
  assign done_o   = r_done;

  // Next-state and completion decode
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          if (issue_len_i != '0) begin
            w_state_nxt = ACTIVE;
          end else begin
            // Zero-length instruction completes without touching the queue
            w_done_nxt = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (w_push && w_last_acc) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_state_nxt = DRAIN;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // The final write always ends the instruction, whatever state it lands in
    if ((r_state != IDLE) && w_pop && w_last_wr) begin
      w_state_nxt = IDLE;
      w_done_nxt  = 1'b1;
    end
  end

  // State register and one-cycle done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Accepted/written word counters, armed on issue and drained by handshakes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
    end else if (w_issue) begin
      r_acc_cnt <= issue_len_i;
      r_wr_cnt  <= issue_len_i;
    end else begin
      if (w_push) begin
        r_acc_cnt <= r_acc_cnt - 1'b1;
      end
      if (w_pop) begin
        r_wr_cnt <= r_wr_cnt - 1'b1;
      end
    end
  end

  // Queue pointers wrap naturally because Depth is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Entry storage holds data only, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= result_i;
      r_mem_be[r_wr_ptr]   <= mask_i;
    end
  end

`ifdef MUL_RESULT_QUEUE_PERF_EN
  logic [31:0] r_stall_cnt;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) begin
      return val;
    end
    return val + 32'd1;
  endfunction

  // Back-pressure counter: cleared per instruction, saturates at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_issue) begin
      r_stall_cnt <= '0;
    end else if (wvalid_o && !wready_i) begin
      r_stall_cnt <= sat_inc32(r_stall_cnt);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
